// File: rtl/cnt_burst_sched.sv
// Round-robin owner of a shared counter: grants one requester, clears, counts len cycles, pulses done.
// Latency: grant 1 cycle after IDLE sees a request, done at len+2; requests are held off (ignored) while busy.
module cnt_burst_sched #(
    parameter int NUM_REQ   = 4,
    parameter int CNT_WIDTH = 4
) (
    input  logic                         sch_clk,
    input  logic                         sch_rst_n,
    input  logic [NUM_REQ-1:0]           sch_req,
    input  logic [NUM_REQ*CNT_WIDTH-1:0] sch_len,
    input  logic [CNT_WIDTH-1:0]         sch_cnt_i,
    output logic [NUM_REQ-1:0]           sch_grant,
    output logic                         sch_cnt_en,
    output logic                         sch_cnt_clr_n,
    output logic                         sch_busy,
    output logic                         sch_done
);

    localparam int PTR_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

    state_t               state_q;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [CNT_WIDTH-1:0] len_q, len_d;
    logic [PTR_W-1:0]     ptr_q, gidx_q, gidx_d, cand;
    logic                 req_vld;
    logic                 en_q, clr_n_q, busy_q, done_q;

    // Search upward from ptr+1 with wrap; the first hit wins.
    always_comb begin
        req_vld = 1'b0;
        gidx_d  = '0;
        cand    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = PTR_W'((int'(ptr_q) + k) % NUM_REQ);
            if (!req_vld && sch_req[cand]) begin
                req_vld = 1'b1;
                gidx_d  = cand;
            end
        end
        grant_d = '0;
        grant_d[gidx_d] = 1'b1;
        len_d   = sch_len[gidx_d*CNT_WIDTH +: CNT_WIDTH];
    end

    always_ff @(posedge sch_clk) begin
        if (!sch_rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            len_q   <= '0;
            gidx_q  <= '0;
            ptr_q   <= PTR_W'(NUM_REQ - 1);
            en_q    <= 1'b0;
            clr_n_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_vld) begin
                        state_q <= CLEAR;
                        grant_q <= grant_d;
                        len_q   <= len_d;
                        gidx_q  <= gidx_d;
                        busy_q  <= 1'b1;
                        clr_n_q <= 1'b0;
                    end
                end
                CLEAR: begin
                    clr_n_q <= 1'b1;
                    if (len_q == '0) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= RUN;
                        en_q    <= 1'b1;
                    end
                end
                RUN: begin
                    // Leave one count early: the final enabled edge lands the counter on len_q.
                    if (sch_cnt_i == CNT_WIDTH'(len_q - 1'b1)) begin
                        state_q <= DONE;
                        en_q    <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    grant_q <= '0;
                    ptr_q   <= gidx_q;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sch_grant     = grant_q;
    assign sch_cnt_en    = en_q;
    assign sch_cnt_clr_n = clr_n_q;
    assign sch_busy      = busy_q;
    assign sch_done      = done_q;

endmodule

// File: tb/tb_cnt_burst_sched.sv
// Bench for cnt_burst_sched with a behavioural model of the shared counter.
module tb_cnt_burst_sched;

    typedef struct {
        logic [3:0] grant;
        logic [3:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] len;
    logic [3:0]  cnt;
    logic [3:0]  grant;
    logic        en, clr_n, busy, done;
    int          en_seen;
    int          vectors = 0;
    int          miscompares = 0;
    exp_t        sb[$];

    cnt_burst_sched #(.NUM_REQ(4), .CNT_WIDTH(4)) dut (
        .sch_clk       (clk),
        .sch_rst_n     (rst_n),
        .sch_req       (req),
        .sch_len       (len),
        .sch_cnt_i     (cnt),
        .sch_grant     (grant),
        .sch_cnt_en    (en),
        .sch_cnt_clr_n (clr_n),
        .sch_busy      (busy),
        .sch_done      (done)
    );

    always #5 clk = ~clk;

    // Shared counter: clear is the AND of reset and the scheduler's clear.
    always @(posedge clk) begin
        if (!(rst_n && clr_n)) cnt <= '0;
        else if (en)           cnt <= cnt + 1'b1;
    end

    always @(posedge clk) begin
        if (!clr_n)  en_seen <= 0;
        else if (en) en_seen <= en_seen + 1;
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_done(input int budget, output bit seen, output int cycles);
        seen   = 1'b0;
        cycles = 0;
        while (!seen && cycles < budget) begin
            step();
            cycles++;
            if (done) seen = 1'b1;
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req   = '0;
        len   = '0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 4'hf;
        len   = 16'hffff;
        for (int c = 0; c < 3; c++) begin
            step();
            vectors++;
            if ({grant, en, clr_n, busy, done} !== 8'b0000_0100) begin
                miscompares++;
                $display("FAIL reset_outputs: got %b expected %b", {grant, en, clr_n, busy, done}, 8'b0000_0100);
            end
        end
        req   = '0;
        rst_n = 1'b1;
        step();
        vectors++;
        if ({grant, busy} !== 5'b0) begin
            miscompares++;
            $display("FAIL idle_after_reset: got %b expected 00000", {grant, busy});
        end
    endtask

    task automatic test_single();
        logic [7:0] want;
        exp_t       e;
        apply_reset();
        req = 4'b0001;
        len = 16'h0005;
        sb.push_back('{4'b0001, 4'd5});
        for (int c = 1; c <= 9; c++) begin
            step();
            if (c == 1) req = '0;
            want = {(c <= 7) ? 4'b0001 : 4'b0000, (c >= 2 && c <= 6), (c != 1), (c <= 7), (c == 7)};
            vectors++;
            if ({grant, en, clr_n, busy, done} !== want) begin
                miscompares++;
                $display("FAIL single_cycle%0d: got %b expected %b", c, {grant, en, clr_n, busy, done}, want);
            end
            if (c == 7) begin
                e = sb.pop_front();
                vectors++;
                if (cnt !== e.cnt || en_seen != 5) begin
                    miscompares++;
                    $display("FAIL single_done: got cnt=%0d en=%0d expected cnt=%0d en=5", cnt, en_seen, e.cnt);
                end
            end
        end
    endtask

    task automatic test_round_robin();
        bit   seen;
        int   cyc;
        exp_t e;
        apply_reset();
        req = 4'b1111;
        len = 16'h2222;
        sb.push_back('{4'b0001, 4'd2});
        sb.push_back('{4'b0010, 4'd2});
        sb.push_back('{4'b0100, 4'd2});
        sb.push_back('{4'b1000, 4'd2});
        sb.push_back('{4'b0001, 4'd2});
        for (int i = 0; i < 5; i++) begin
            wait_done(20, seen, cyc);
            e = sb.pop_front();
            vectors++;
            if (!seen || grant !== e.grant || cnt !== e.cnt || en_seen != 2 || cyc != ((i == 0) ? 4 : 5)) begin
                miscompares++;
                $display("FAIL rr_burst%0d: got seen=%0d grant=%b cnt=%0d en=%0d gap=%0d expected grant=%b cnt=%0d en=2 gap=%0d",
                         i, seen, grant, cnt, en_seen, cyc, e.grant, e.cnt, (i == 0) ? 4 : 5);
            end
        end
        req = '0;
        step();
        step();
    endtask

    task automatic test_len_limits();
        bit         seen;
        int         cyc;
        exp_t       e;
        logic [3:0] lens [3];
        lens[0] = 4'd0;
        lens[1] = 4'd15;
        lens[2] = 4'd1;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            req = 4'b0001;
            len = {12'h000, lens[i]};
            sb.push_back('{4'b0001, lens[i]});
            wait_done(40, seen, cyc);
            req = '0;
            e = sb.pop_front();
            vectors++;
            if (!seen || grant !== e.grant || cnt !== e.cnt || en_seen != int'(lens[i]) || cyc != int'(lens[i]) + 2) begin
                miscompares++;
                $display("FAIL len%0d: got seen=%0d grant=%b cnt=%0d en=%0d at=%0d expected grant=%b cnt=%0d en=%0d at=%0d",
                         lens[i], seen, grant, cnt, en_seen, cyc, e.grant, e.cnt, lens[i], int'(lens[i]) + 2);
            end
            step();
        end
    endtask

    task automatic test_req_drop();
        bit   seen;
        int   cyc;
        exp_t e;
        apply_reset();
        req = 4'b0010;
        len = 16'h0060;
        sb.push_back('{4'b0010, 4'd6});
        step();
        step();
        step();
        req = '0;
        len = 16'h0030;
        wait_done(30, seen, cyc);
        e = sb.pop_front();
        vectors++;
        if (!seen || grant !== e.grant || cnt !== e.cnt || en_seen != 6) begin
            miscompares++;
            $display("FAIL req_drop: got seen=%0d grant=%b cnt=%0d en=%0d expected grant=%b cnt=%0d en=6",
                     seen, grant, cnt, en_seen, e.grant, e.cnt);
        end
        step();
        step();
        vectors++;
        if ({grant, busy} !== 5'b0) begin
            miscompares++;
            $display("FAIL req_drop_idle: got %b expected 00000", {grant, busy});
        end
    endtask

    task automatic test_mid_reset();
        bit   seen;
        int   cyc;
        exp_t e;
        apply_reset();
        req = 4'b0001;
        len = 16'h0001;
        sb.push_back('{4'b0001, 4'd1});
        wait_done(20, seen, cyc);
        req = '0;
        e = sb.pop_front();
        vectors++;
        if (!seen || grant !== e.grant || cnt !== e.cnt) begin
            miscompares++;
            $display("FAIL pre_burst: got seen=%0d grant=%b cnt=%0d expected grant=%b cnt=%0d", seen, grant, cnt, e.grant, e.cnt);
        end
        step();
        req = 4'b0100;
        len = 16'h0800;
        step();
        req = '0;
        step();
        step();
        step();
        vectors++;
        if ({grant, en} !== 5'b0100_1) begin
            miscompares++;
            $display("FAIL mid_run: got %b expected 01001", {grant, en});
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        vectors++;
        if ({grant, en, clr_n, busy, done, cnt} !== 12'b0000_0100_0000) begin
            miscompares++;
            $display("FAIL mid_reset: got %b expected 000001000000", {grant, en, clr_n, busy, done, cnt});
        end
        for (int c = 0; c < 4; c++) begin
            step();
            vectors++;
            if ({done, busy} !== 2'b00) begin
                miscompares++;
                $display("FAIL no_done_after_reset%0d: got %b expected 00", c, {done, busy});
            end
        end
        // Stale pointer would be 0 here and hand requester 1 the win.
        req = 4'b0011;
        len = 16'h0011;
        sb.push_back('{4'b0001, 4'd1});
        wait_done(20, seen, cyc);
        req = '0;
        e = sb.pop_front();
        vectors++;
        if (!seen || grant !== e.grant || cnt !== e.cnt) begin
            miscompares++;
            $display("FAIL ptr_after_reset: got seen=%0d grant=%b cnt=%0d expected grant=%b cnt=%0d", seen, grant, cnt, e.grant, e.cnt);
        end
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        req   = '0;
        len   = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_len_limits();
        test_req_drop();
        test_mid_reset();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
